// File: rtl/i2c_pkg.sv
//------------------------------------------------------------------
// i2c_pkg: shared FSM state encoding and I2C constants    rev 1.0
//------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

  localparam int unsigned I2C_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
//------------------------------------------------------------------
// i2c_line_filter: 2-flop synchronizer plus FILT-sample glitch filter  rev 1.0
//------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_line
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Everything resets to the idle-bus level so reset release looks like a quiet bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_line = r_level;

endmodule

`default_nettype wire

// File: rtl/i2c_temp_target.sv
//------------------------------------------------------------------
// i2c_temp_target: I2C target that reports temp_word and captures writes  rev 1.0
//------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h4B,
  parameter int         FILT = 3
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] temp_word,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy
);

  logic       w_scl, w_sda;
  logic       r_scl_d, r_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_state_e r_state, w_state_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic       r_sda_oe, w_oe_nxt;
  logic [15:0] r_shadow, w_shadow_nxt;
  logic       r_byte_sel, w_byte_sel_nxt;
  logic       r_rw, w_rw_nxt;
  logic [7:0] w_rx_data_nxt;
  logic       w_rx_valid_nxt, w_busy_nxt;

  logic [7:0] w_byte_in;
  logic [7:0] w_tx_byte;
  logic       w_tx_bit;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .clk    (clk_50MHz),
    .rst_n  (reset_n),
    .i_line (SCL),
    .o_line (w_scl)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .clk    (clk_50MHz),
    .rst_n  (reset_n),
    .i_line (SDA),
    .o_line (w_sda)
  );

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte_in  = {r_shift, w_sda};
  assign w_tx_byte  = r_byte_sel ? r_shadow[7:0] : r_shadow[15:8];
  assign w_tx_bit   = w_tx_byte[3'd7 - r_bitcnt[2:0]];

  // Open-drain: only ever pull low or float.
  assign SDA = r_sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_oe_nxt       = r_sda_oe;
    w_shadow_nxt   = r_shadow;
    w_byte_sel_nxt = r_byte_sel;
    w_rw_nxt       = r_rw;
    w_rx_data_nxt  = rx_data;
    w_rx_valid_nxt = 1'b0;
    w_busy_nxt     = busy;

    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_bitcnt_nxt = '0;
      w_oe_nxt     = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_bitcnt_nxt = '0;
      w_oe_nxt     = 1'b0;
      w_busy_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte_in[6:0];
            if (r_bitcnt == 4'(I2C_BITS - 1)) begin
              w_bitcnt_nxt = '0;
              if (w_byte_in[7:1] == ADDR) begin
                w_state_nxt = ST_ADDR_ACK;
                w_rw_nxt    = w_byte_in[0];
                if (w_byte_in[0]) begin
                  w_shadow_nxt   = temp_word;
                  w_byte_sel_nxt = 1'b0;
                end
              end else begin
                w_state_nxt = ST_WAIT_STOP;
              end
            end else begin
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end

        // First SCL fall drives the ACK, second ends it; a read presents its MSB on that second fall.
        ST_ADDR_ACK, ST_RX_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_bitcnt_nxt = '0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_state_nxt = ST_TX_BYTE;
                w_oe_nxt    = ~w_tx_byte[7];
              end else begin
                w_state_nxt = ST_RX_BYTE;
                w_oe_nxt    = 1'b0;
              end
            end
          end
        end

        ST_RX_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte_in[6:0];
            if (r_bitcnt == 4'(I2C_BITS - 1)) begin
              w_bitcnt_nxt   = '0;
              w_rx_data_nxt  = w_byte_in;
              w_rx_valid_nxt = 1'b1;
              w_state_nxt    = ST_RX_ACK;
            end else begin
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end

        // r_bitcnt counts master sample edges; the fall after the eighth hands the bus back.
        ST_TX_BYTE: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'(I2C_BITS)) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = ST_TX_ACK;
            end else begin
              w_oe_nxt = ~w_tx_bit;
            end
          end
        end

        ST_TX_ACK: begin
          w_oe_nxt = 1'b0;
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_state_nxt    = ST_TX_BYTE;
              w_bitcnt_nxt   = '0;
              w_byte_sel_nxt = ~r_byte_sel;
            end else begin
              w_state_nxt = ST_WAIT_STOP;
            end
          end
        end

        default: begin
          w_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_shadow   <= 16'h0000;
      r_byte_sel <= 1'b0;
      r_rw       <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_shadow   <= w_shadow_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_rw       <= w_rw_nxt;
      rx_data    <= w_rx_data_nxt;
      rx_valid   <= w_rx_valid_nxt;
      busy       <= w_busy_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_temp_target.sv
//------------------------------------------------------------------
// tb_i2c_temp_target: bit-banged I2C master with transaction-level reference  rev 1.0
//------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_temp_target;

  localparam logic [6:0] ADDR = 7'h4B;
  localparam int         FILT = 3;
  localparam int         Q    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda_oe = 1'b0;
  logic [15:0] temp_word = 16'h0000;
  wire         sda_bus;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;

  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_temp_target #(.ADDR(ADDR), .FILT(FILT)) u_dut (
    .clk_50MHz (clk),
    .reset_n   (rst_n),
    .SCL       (scl),
    .SDA       (sda_bus),
    .temp_word (temp_word),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rxq[$];
  int         dut_low = 0;

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (!m_sda_oe && sda_bus === 1'b0) dut_low++;
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic start_c();
    wq(); m_sda_oe = 1'b0;
    wq(); scl = 1'b1;
    wq(2); m_sda_oe = 1'b1;
    wq(2); scl = 1'b0;
  endtask

  task automatic stop_c();
    wq(); m_sda_oe = 1'b1;
    wq(); scl = 1'b1;
    wq(2); m_sda_oe = 1'b0;
    wq(2);
  endtask

  task automatic wbit(input logic b);
    wq(); m_sda_oe = !b;
    wq(); scl = 1'b1;
    wq(2); scl = 1'b0;
  endtask

  // Same bit timing, with 2-cycle SCL spikes while low and while high.
  task automatic wbit_g(input logic b);
    wq(); m_sda_oe = !b;
    repeat (3) @(negedge clk); scl = 1'b1;
    repeat (2) @(negedge clk); scl = 1'b0;
    repeat (3) @(negedge clk); scl = 1'b1;
    repeat (6) @(negedge clk); scl = 1'b0;
    repeat (2) @(negedge clk); scl = 1'b1;
    repeat (8) @(negedge clk); scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    wq(); m_sda_oe = 1'b0;
    wq(); scl = 1'b1;
    wq(); b = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    wq(); scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (glitch) wbit_g(d[i]);
      else        wbit(d[i]);
    end
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(nack);
  endtask

  // Reference: shadow is temp_word as it stood at the address phase; bytes alternate hi/lo.
  task automatic do_read(input logic [6:0] a, input int n, input logic [15:0] tw_after);
    logic        ack;
    logic [7:0]  d;
    logic [15:0] cap;
    logic        hit;
    hit = (a == ADDR);
    cap = temp_word;
    dut_low = 0;
    start_c();
    chk("busy_after_start", busy, 1);
    wbyte({a, 1'b1}, 1'b0, ack);
    chk("rd_addr_ack", ack, hit ? 0 : 1);
    temp_word = tw_after;
    if (hit) begin
      for (int i = 0; i < n; i++) begin
        rbyte(d, (i == n - 1));
        chk("rd_byte", d, (i % 2 == 0) ? cap[15:8] : cap[7:0]);
      end
    end else begin
      rbyte(d, 1'b1);
      chk("rd_nomatch_byte", d, 8'hFF);
    end
    stop_c();
    if (!hit) chk("nomatch_sda_driven", dut_low, 0);
    chk("busy_after_stop", busy, 0);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] data,
                          input logic glitch, input logic do_stop);
    logic       ack;
    logic       hit;
    logic [7:0] expq[$];
    logic [7:0] d;
    hit = (a == ADDR);
    rxq.delete();
    start_c();
    wbyte({a, 1'b0}, 1'b0, ack);
    chk("wr_addr_ack", ack, hit ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      d = data[31 - 8*i -: 8];
      wbyte(d, glitch, ack);
      chk("wr_data_ack", ack, hit ? 0 : 1);
      if (hit) expq.push_back(d);
    end
    chk("rx_count", rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      chk("rx_byte", rxq[i], expq[i]);
    if (do_stop) begin
      stop_c();
      chk("busy_after_stop", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        b;
    logic [6:0]  a;
    int          kind;

    repeat (5) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_bus, 1);
    rst_n = 1'b1;
    wq(2);
    chk("idle_busy", busy, 0);

    temp_word = 16'h1A80;
    do_read(ADDR, 2, 16'h1A80);

    do_write(ADDR, 2, 32'h03C5_0000, 1'b0, 1'b1);

    do_read(7'h48, 1, temp_word);

    temp_word = 16'hBEEF;
    do_read(ADDR, 3, 16'h0000);

    // Write followed by repeated START into a read.
    do_write(ADDR, 1, 32'h0000_0000, 1'b0, 1'b0);
    temp_word = 16'h5A3C;
    do_read(ADDR, 2, 16'hFFFF);

    do_write(ADDR, 1, 32'hA500_0000, 1'b1, 1'b1);

    // Reset in the middle of a byte in which the target holds SDA low.
    temp_word = 16'h0000;
    start_c();
    wbyte({ADDR, 1'b1}, 1'b0, b);
    chk("rst_case_addr_ack", b, 0);
    for (int i = 0; i < 3; i++) rbit(b);
    wq();
    chk("rst_case_drv", sda_bus, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_case_release", sda_bus, 1);
    chk("rst_case_busy", busy, 0);
    wq();
    rst_n = 1'b1;
    dut_low = 0;
    for (int i = 0; i < 6; i++) rbit(b);
    stop_c();
    chk("rst_case_ignore", dut_low, 0);
    temp_word = 16'hC0DE;
    do_read(ADDR, 2, 16'h1234);
    do_write(ADDR, 2, 32'h7E81_0000, 1'b0, 1'b1);

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      temp_word = 16'($urandom);
      case (kind)
        0: do_read(ADDR, $urandom_range(1, 3), 16'($urandom));
        1: do_write(ADDR, $urandom_range(1, 4), $urandom, 1'b0, 1'b1);
        2: begin
          a = 7'($urandom);
          if (a == ADDR) a = a ^ 7'h01;
          if ($urandom_range(0, 1) == 0) do_read(a, 1, 16'($urandom));
          else do_write(a, $urandom_range(1, 2), $urandom, 1'b0, 1'b1);
        end
        default: begin
          do_write(ADDR, $urandom_range(1, 2), $urandom, 1'b0, 1'b0);
          temp_word = 16'($urandom);
          do_read(ADDR, $urandom_range(1, 3), 16'($urandom));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_temp_target.md
I2C_TEMP_TARGET -- requirements
Module: i2c_temp_target

Interface
REQ-001 Parameter: ADDR, default 7'h4B, 7-bit target address the block responds to.
REQ-002 Parameter: FILT, default 3, number of consecutive equal samples required to accept a new SCL/SDA level.
REQ-003 clk_50MHz  input  1  sole clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SCL  input  1  I2C clock from the master.
REQ-006 SDA  inout  1  I2C data; the block drives only 1'b0 or high-Z, never 1'b1.
REQ-007 temp_word  input  16  temperature value to report, MSB byte first.
REQ-008 rx_data  output  8  last byte written by the master.
REQ-009 rx_valid  output  1  one-cycle strobe; rx_data holds a new byte.
REQ-010 busy  output  1  high from an accepted START until the next STOP.

Function
REQ-011 SCL and SDA shall each pass through a 2-flop synchronizer, then a FILT-sample glitch filter; all decisions use the filtered levels only.
REQ-012 START = filtered SDA falling while filtered SCL high; STOP = filtered SDA rising while filtered SCL high; bits are sampled on filtered SCL rising edge.
REQ-013 FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-014 START (including repeated START) from any state shall move to ADDR with the bit counter cleared; STOP from any state shall move to IDLE and release SDA.
REQ-015 ADDR: shift 8 bits MSB first; on bit 8, if bits[7:1]==ADDR go to ADDR_ACK, otherwise go to WAIT_STOP and never drive SDA.
REQ-016 ADDR_ACK: pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge; R/W=1 then enters TX_BYTE, R/W=0 enters RX_BYTE.
REQ-017 On read address match, temp_word shall be latched into a 16-bit shadow register; the shadow is not updated again within that transfer.
REQ-018 TX_BYTE: the first byte is shadow[15:8], then shadow[7:0], then wraps back to [15:8]; each bit is presented on an SCL falling edge and held through the following SCL high.
REQ-019 TX_BYTE: bit value 1 means SDA is released (high-Z); bit value 0 means SDA is pulled low.
REQ-020 TX_ACK: SDA released; master ACK (SDA low at SCL rise) leads to TX_BYTE with the next byte; NACK leads to WAIT_STOP.
REQ-021 RX_BYTE: shift 8 bits MSB first, then go to RX_ACK, with rx_data updated and rx_valid pulsed exactly one clk_50MHz cycle when bit 8 is sampled.
REQ-022 RX_ACK: ACK every written byte (same drive timing as REQ-016), then return to RX_BYTE.
REQ-023 WAIT_STOP: SDA released; only START or STOP leaves this state.
REQ-024 The block shall never stretch SCL.
REQ-025 Latency: SDA drive change shall occur no later than FILT+4 clk_50MHz cycles after the raw SCL falling edge.

Reset
REQ-026 While reset_n is low: FSM=IDLE, SDA high-Z, rx_data=8'h00, rx_valid=0, busy=0, shadow=16'h0000, counters cleared.
REQ-027 Synchronizer and filter flops shall reset to 1 (idle bus), so deassertion of reset creates no false START.
REQ-028 Reset asserted mid-transfer shall release SDA immediately (asynchronously); after release the block ignores the bus until the next START.

Structure
REQ-029 FSM state enumeration and the I2C bit-count constant (8) shall live in a shared package, i2c_pkg.
REQ-030 The synchronizer plus glitch filter shall be one sub-module, i2c_line_filter, instantiated once each for SCL and SDA.

Verification
REQ-031 Read 0x4B, temp_word=16'h1A80, master ACKs byte 1 and NACKs byte 2, then STOP -> address ACKed, bytes 8'h1A then 8'h80 on SDA, busy returns to 0.
REQ-032 Write 0x4B then data 8'h03 and 8'hC5 -> three ACKs, two rx_valid pulses carrying 8'h03 then 8'hC5.
REQ-033 Address 0x48 (read) -> no ACK, SDA never driven, FSM remains in WAIT_STOP until STOP.
REQ-034 Read of 3 bytes with temp_word=16'hBEEF, temp_word changed to 16'h0000 after the address ACK -> 8'hBE, 8'hEF, 8'hBE returned.
REQ-035 Write 8'h00, then repeated START with a read -> read proceeds normally with correct temp bytes.
REQ-036 Glitches of 2 cycles on SCL, plus reset_n pulsed low mid-byte -> no extra bit sampled, SDA released at once, next transfer correct.
